// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides and a stored carry for ADC/SBC chains.
// Stage 1 registers operands and the adder output; stage 2 selects the result and forms {V,N,Z,C}.
module alu_pipe #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_use_carry,
  input  logic             clr_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic             carry_q
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  logic             s1_valid, s2_valid;
  logic [WIDTH-1:0] a1, b1, sum1;
  logic [2:0]       op1;
  logic             cout1;
  logic             adv1, adv2, accept;

  assign adv2      = ~s2_valid | out_ready;
  assign adv1      = ~s1_valid | adv2;
  assign in_ready  = adv1 & ~rst;
  assign accept    = in_valid & in_ready;
  assign out_valid = s2_valid;

  logic             is_add, is_sub, cin, cout;
  logic [WIDTH-1:0] b_add, sum;

  always_comb begin
    is_add = (in_op == OP_ADD);
    is_sub = (in_op == OP_SUB);
    b_add  = is_sub ? ~in_b : in_b;
    if (is_sub)
      cin = in_use_carry ? carry_q : 1'b1;
    else
      cin = (is_add & in_use_carry) ? carry_q : 1'b0;
    {cout, sum} = {1'b0, in_a} + {1'b0, b_add} + {{WIDTH{1'b0}}, cin};
  end

  // The accepted op always sees the pre-clear carry; clr_carry only wins the register update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      a1       <= '0;
      b1       <= '0;
      op1      <= OP_ADD;
      sum1     <= '0;
      cout1    <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      if (adv1) s1_valid <= accept;
      if (accept) begin
        a1    <= in_a;
        b1    <= in_b;
        op1   <= in_op;
        sum1  <= sum;
        cout1 <= cout;
      end
      if (clr_carry)
        carry_q <= 1'b0;
      else if (accept && (is_add || is_sub))
        carry_q <= cout;
    end
  end

  logic [SHW-1:0]   sh;
  logic [WIDTH:0]   shl_w, shr_w, sra_w;
  logic [WIDTH-1:0] b_eff, res;
  logic             c_flag, v_flag;

  always_comb begin
    sh     = b1[SHW-1:0];
    // One extra bit on the shifted-out side captures the last bit lost (0 when sh==0).
    shl_w  = {1'b0, a1} << sh;
    shr_w  = {a1, 1'b0} >> sh;
    sra_w  = $signed({a1, 1'b0}) >>> sh;
    b_eff  = (op1 == OP_SUB) ? ~b1 : b1;
    res    = '0;
    c_flag = 1'b0;
    v_flag = 1'b0;
    case (op1)
      OP_ADD, OP_SUB: begin
        res    = sum1;
        c_flag = cout1;
        v_flag = (a1[WIDTH-1] == b_eff[WIDTH-1]) & (sum1[WIDTH-1] != a1[WIDTH-1]);
      end
      OP_AND: res = a1 & b1;
      OP_OR:  res = a1 | b1;
      OP_XOR: res = a1 ^ b1;
      OP_SHL: begin
        res    = shl_w[WIDTH-1:0];
        c_flag = shl_w[WIDTH];
      end
      OP_SHR: begin
        res    = shr_w[WIDTH:1];
        c_flag = shr_w[0];
      end
      OP_SRA: begin
        res    = sra_w[WIDTH:1];
        c_flag = sra_w[0];
      end
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid   <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= res;
        out_flags  <= {v_flag, res[WIDTH-1], (res == '0), c_flag};
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe (WIDTH=8): directed scenarios plus random traffic against an arithmetic reference model.
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [7:0] in_a, in_b;
  logic [2:0] in_op;
  logic       in_use_carry, clr_carry;
  logic       out_valid, out_ready;
  logic [7:0] out_result;
  logic [3:0] out_flags;
  logic       carry_q;

  alu_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .in_use_carry(in_use_carry), .clr_carry(clr_carry),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags),
    .carry_q(carry_q)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [11:0] q[$];
  logic        m_carry = 1'b0;
  logic        stall_prev = 1'b0;
  logic [7:0]  stall_res, last_res;
  logic [3:0]  stall_flags, last_flags;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the operation's meaning.
  task automatic ref_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input logic uc, input logic cy,
                        output logic [7:0] r, output logic [3:0] f, output logic co);
    int t, sv, sa, sb, sh, cin;
    logic c, v;
    sa = $signed(a); sb = $signed(b); sh = int'(b[2:0]);
    c = 1'b0; v = 1'b0; r = 8'h00;
    case (op)
      3'd0: begin
        cin = (uc && cy) ? 1 : 0;
        t = int'(a) + int'(b) + cin; r = t[7:0]; c = (t > 255);
        sv = sa + sb + cin; v = (sv > 127) || (sv < -128);
      end
      3'd1: begin
        cin = uc ? int'(cy) : 1;
        t = int'(a) + (255 - int'(b)) + cin; r = t[7:0]; c = (t > 255);
        sv = sa - sb - 1 + cin; v = (sv > 127) || (sv < -128);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin
        t = int'(a) * (1 << sh); r = t[7:0]; c = (sh != 0) && t[8];
      end
      3'd6: begin
        t = int'(a) / (1 << sh); r = t[7:0];
        c = (sh != 0) && ((int'(a) / (1 << (sh - 1))) % 2 == 1);
      end
      default: begin
        t = sa >>> sh; r = t[7:0];
        c = (sh != 0) && (((sa >>> (sh - 1)) & 1) == 1);
      end
    endcase
    co = c;
    f = {v, r[7], (r == 8'h00), c};
  endtask

  task automatic tick(output bit acc);
    bit emit;
    logic [11:0] e;
    logic [7:0] er;
    logic [3:0] ef;
    logic eco;
    #2;
    acc  = in_valid & in_ready;
    emit = out_valid & out_ready;
    chk("carry_q", carry_q, m_carry);
    chk("in_ready", in_ready, (q.size() < 2) || out_ready);
    if (stall_prev) begin
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_result", out_result, stall_res);
      chk("stall_flags", out_flags, stall_flags);
    end
    if (emit) begin
      if (q.size() == 0) chk("spurious_valid", out_valid, 1'b0);
      else begin
        e = q.pop_front();
        chk("result", out_result, e[7:0]);
        chk("flags", out_flags, e[11:8]);
        last_res = out_result; last_flags = out_flags;
      end
    end
    stall_prev  = out_valid & ~out_ready;
    stall_res   = out_result;
    stall_flags = out_flags;
    eco = 1'b0;
    if (acc) begin
      ref_op(in_a, in_b, in_op, in_use_carry, m_carry, er, ef, eco);
      q.push_back({ef, er});
    end
    if (clr_carry) m_carry = 1'b0;
    else if (acc && (in_op == 3'd0 || in_op == 3'd1)) m_carry = eco;
    cyc++;
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input logic uc);
    bit acc;
    int n;
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_use_carry = uc; clr_carry = 1'b0;
    acc = 1'b0; n = 0;
    while (!acc && n < 20) begin tick(acc); n++; end
    if (!acc) chk("send_timeout", in_ready, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    int n;
    in_valid = 1'b0; out_ready = 1'b1; n = 0;
    while (q.size() > 0 && n < 50) begin tick(acc); n++; end
    if (q.size() > 0) chk("drain_timeout", q.size(), 0);
  endtask

  initial begin
    bit acc;
    int k, n;
    logic [7:0] bp_a[6];
    rst = 1'b1; in_valid = 1'b0; in_a = 0; in_b = 0; in_op = 0;
    in_use_carry = 1'b0; clr_carry = 1'b0; out_ready = 1'b1;
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_carry", carry_q, 1'b0);
    chk("rst_result", out_result, 8'h00);
    chk("rst_flags", out_flags, 4'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // 1: signed overflow
    send(8'h7F, 8'h01, 3'd0, 1'b0); drain();
    chk("t1_result", last_res, 8'h80);
    chk("t1_flags", last_flags, 4'b1100);
    // 2: subtraction
    send(8'h05, 8'h05, 3'd1, 1'b0); drain();
    chk("t2a_flags", last_flags, 4'b0011);
    send(8'h03, 8'h05, 3'd1, 1'b0); drain();
    chk("t2b_result", last_res, 8'hFE);
    // 3: carry chain
    send(8'hFF, 8'h01, 3'd0, 1'b0);
    send(8'h00, 8'h00, 3'd0, 1'b1); drain();
    chk("t3_adc_result", last_res, 8'h01);
    clr_carry = 1'b1; tick(acc); clr_carry = 1'b0;
    send(8'h00, 8'h00, 3'd0, 1'b1); drain();
    chk("t3_clr_flags", last_flags, 4'b0010);
    // 4: shifts
    send(8'h81, 8'h01, 3'd5, 1'b0);
    send(8'h81, 8'h01, 3'd6, 1'b0);
    send(8'h80, 8'h03, 3'd7, 1'b0);
    send(8'h81, 8'hF8, 3'd5, 1'b0); drain();
    chk("t4_sh0_result", last_res, 8'h81);
    chk("t4_sh0_flags", last_flags, 4'b0100);

    // 5: backpressure
    for (int i = 0; i < 6; i++) bp_a[i] = 8'(8'h10 * i + 8'h3);
    out_ready = 1'b0; k = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_a = bp_a[k]; in_b = 8'h01; in_op = 3'd0; in_use_carry = 1'b0;
      tick(acc);
      if (acc) k++;
    end
    chk("bp_accepted", k, 2);
    out_ready = 1'b1; n = 0;
    while (k < 6 && n < 30) begin
      in_valid = 1'b1; in_a = bp_a[k];
      tick(acc);
      if (acc) k++;
      n++;
    end
    chk("bp_all_accepted", k, 6);
    drain();

    // 6: reset with both stages full
    out_ready = 1'b0;
    send(8'hFF, 8'h01, 3'd0, 1'b0);
    send(8'hFF, 8'h01, 3'd0, 1'b0);
    rst = 1'b1; #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_carry", carry_q, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b0);
    q.delete(); m_carry = 1'b0; stall_prev = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_a = 8'h03; in_b = 8'h04; in_op = 3'd0; in_use_carry = 1'b0;
    tick(acc);
    chk("post_rst_accept", acc, 1'b1);
    in_valid = 1'b0; n = 1;
    while (!out_valid && n < 10) begin tick(acc); n++; end
    chk("post_rst_latency", n, 2);
    drain();
    chk("post_rst_result", last_res, 8'h07);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_a = 8'($urandom); in_b = 8'($urandom); in_op = 3'($urandom);
      in_use_carry = 1'($urandom); clr_carry = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick(acc);
    end
    clr_carry = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, 2-stage pipelined ALU: the registered successor of the team's combinational 8-bit ALU.
- Adds generic WIDTH, full-width shift amount, XOR and arithmetic-right-shift ops, and a carry-chained ADC/SBC mode backed by a stored carry flag.
- Has valid/ready handshakes on both sides, so it can sit between an operand sequencer and a result FIFO inside the TinyTapeout top wrapper.

Parameters:
WIDTH, 8, operand/result width in bits (>=4, power of two)
SHW, $clog2(WIDTH), shift-amount width taken from in_b[SHW-1:0]

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept operand beat
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B / shift amount (low SHW bits)
in_op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 SRA
in_use_carry  input  1  ADD->ADC, SUB->SBC using stored carry; ignored for other ops
clr_carry  input  1  synchronous clear of stored carry flag
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result
out_result  output  WIDTH  result
out_flags  output  4  {V,N,Z,C} for this result
carry_q  output  1  stored carry flag

Behaviour:
- Reset (async, rst=1): s1_valid=0, s2_valid=0, out_valid=0, out_result=0, out_flags=0, carry_q=0, in_ready=0 while rst=1. in_ready is 1 from the first cycle after release.
- Any op in flight is discarded on reset; no partial beat emerges.
- Handshakes:
  - Accept when in_valid&in_ready. Emit when out_valid&out_ready.
  - adv2 = ~s2_valid | out_ready. adv1 = ~s1_valid | adv2. in_ready = adv1 (combinational from out_ready; no registered skid).
  - Latency 2 cycles accept->out_valid with no stall. Throughput 1 beat/cycle. Order preserved.
  - Stalled stages hold their contents; no beat is lost or duplicated.
  - out_result and out_flags are stable while out_valid=1 and out_ready=0.
- Stage 1 (on accept): registers a, b, op and the adder output {cout, sum}.
  - cin = SUB ? (use_carry ? carry_q : 1) : (ADD&use_carry ? carry_q : 0).
  - Adder operand = SUB ? ~b : b.
- Stored carry:
  - carry_q <= cout on accept of ADD/SUB; other ops leave it unchanged. ADC/SBC therefore always see the carry of the most recently accepted ADD/SUB, independent of pipeline stalls.
  - clr_carry takes priority over an update in the same cycle, but the accepted op still uses the pre-clear carry_q as its cin.
- Stage 2 (when adv2): selects the result and computes the flags.
  - ADD/SUB: result = sum; C = cout (SUB: 1 = no borrow); V = (a[MSB]==b'[MSB]) & (sum[MSB]!=a[MSB]), where b' is the adder operand.
  - AND/OR/XOR: bitwise result; C = 0; V = 0.
  - SHL/SHR/SRA: shift a by sh = b[SHW-1:0]. SRA replicates a[MSB]. C = last bit shifted out (SHL: a[WIDTH-sh]; SHR/SRA: a[sh-1]); sh=0 gives C = 0. V = 0.
  - Z = (result==0). N = result[MSB].
  - b bits above SHW are ignored for shifts.
- Flags never carry over between beats; each beat's out_flags describe only that beat.

Test Plan:
1. WIDTH=8, ADD 0x7F+0x01 -> 2 cycles later out_result=0x80, flags V=1 N=1 Z=0 C=0; carry_q=0.
2. SUB 0x05-0x05 -> 0x00, Z=1 C=1 V=0; then SUB 0x03-0x05 -> 0xFE, N=1 C=0.
3. Carry chain: ADD 0xFF+0x01 -> 0x00 C=1; then ADC 0x00+0x00 -> 0x01 C=0; then clr_carry for one cycle, then ADC 0x00+0x00 -> 0x00 Z=1.
4. Shifts: SHL 0x81 by 1 -> 0x02 C=1; SHR 0x81 by 1 -> 0x40 C=1; SRA 0x80 by 3 -> 0xF0 N=1 C=0; SHL 0x81 by 0 -> 0x81 C=0.
5. Backpressure: stream 6 ADD beats with out_ready=0 -> in_ready drops after 2 accepted. Release out_ready -> all 6 results appear in order, none lost or duplicated, outputs stable while stalled.
6. Reset mid-stream: assert rst with both stages valid -> out_valid=0, carry_q=0 immediately. After release, the first new beat emerges 2 cycles after accept.
